hit_rate_counter: RTL and testbench
===================================

Name: hit_rate_counter

Overview:
- Downstream consumer of the real-time clock block's interval signals. Counts discriminator hits from one MPPC channel over intervals bounded by transitions of a clock-block output, e.g. the 1 s toggle or the 1 min toggle.
- At each interval boundary, the block latches the count into a snapshot register for the readout logic.
- Snapshot delivery uses a valid/ack handshake. The block also reports saturation and lost snapshots.

Parameters:
- CNT_W, 24, width of the hit accumulator and the COUNT output.
- SYNC_STAGES, 2, number of flip-flops in the HIT synchroniser chain. Legal values are 2 or more.

Ports:
- CLK, in, 1, system clock. This is the same clock as the real-time clock block.
- RST, in, 1, asynchronous active-high reset.
- HIT, in, 1, raw discriminator output. It is asynchronous to CLK. Minimum high and low time is 2 CLK periods.
- GATE, in, 1, interval toggle from the real-time clock block. It is synchronous to CLK. Every transition, rising or falling, is one interval boundary.
- ENABLE, in, 1, counting enable. It is sampled every cycle.
- COUNT, out, CNT_W, hit count of the last completed interval.
- VALID, out, 1, high while an unacknowledged snapshot is held.
- ACK, in, 1, readout consumes the snapshot. It is honoured only while VALID=1.
- OVF, out, 1, the accumulator saturated during the interval held in COUNT.
- LOST, out, 1, sticky flag: a snapshot was overwritten before it was acknowledged.

Behaviour:
- Reset, applied asynchronously:
  - COUNT=0, VALID=0, OVF=0, LOST=0.
  - Accumulator=0, synchroniser flops=0, gate_q=0, primed=0.
  - FSM enters WAIT_EDGE.
- Hit path:
  - HIT passes through SYNC_STAGES flip-flops, then a rising-edge detector.
  - hit_evt is a single-cycle pulse. It occurs SYNC_STAGES+1 cycles after HIT is first sampled high.
  - A hit only counts when ENABLE=1 in the same cycle as hit_evt.
- Gate path:
  - gate_q registers GATE every cycle. gate_evt = (GATE xor gate_q) and primed.
  - primed is set on the first cycle after reset release. This prevents a spurious boundary when GATE=1 at reset release.
- FSM:
  - WAIT_EDGE: hits are discarded and the accumulator is held at 0. On gate_evt, go to RUN and clear the accumulator. No snapshot is produced, because the first interval after reset is partial.
  - RUN: on each counted hit, the accumulator increments by 1.
  - Saturation: the accumulator saturates at 2^CNT_W-1 and never wraps. An internal ovf_acc flag sets at saturation.
  - On gate_evt in RUN, in one cycle:
    - COUNT <= acc + counted hit of this cycle, saturated. A hit coincident with the boundary belongs to the closing interval.
    - OVF <= ovf_acc, or saturation caused by that coincident hit.
    - acc <= 0 and ovf_acc <= 0.
    - VALID <= 1.
  - RUN has no exit except RST.
- Handshake:
  - ACK=1 with VALID=1 and no gate_evt: VALID <= 0 next cycle. COUNT and OVF hold their values.
  - ACK with VALID=0 is ignored.
  - gate_evt while VALID=1 and ACK=0: the new snapshot overwrites COUNT and OVF, VALID stays 1, and LOST <= 1.
  - gate_evt and ACK in the same cycle with VALID=1: the old snapshot counts as consumed. The new snapshot loads, VALID stays 1, and LOST is unchanged.
- LOST clearing: LOST clears on the cycle after an ACK that is accepted with no gate_evt in that cycle. Otherwise it is cleared only by RST.
- Latency and sustained operation:
  - Snapshot outputs update 1 cycle after the GATE transition is visible at the input.
  - Back-to-back gate events, one per cycle, are legal. Each produces a snapshot.
- Reset mid-interval: the partial count is discarded and the FSM returns to WAIT_EDGE.

Test Plan:
1. Reset release with GATE=1, then GATE toggles at t=100 → no snapshot and FSM=RUN. Then 37 HIT pulses, then GATE toggles → VALID=1, COUNT=37, OVF=0.
2. CNT_W=4: 20 hits within one interval, then a GATE edge → COUNT=15, OVF=1. The next interval has 3 hits → COUNT=3, OVF=0.
3. Two GATE edges with no ACK between them, with 5 hits then 8 hits → COUNT=8, VALID=1, LOST=1. Then ACK → VALID=0 and LOST=0 on the next cycle.
4. ACK asserted in the same cycle as a GATE edge while VALID=1 → new COUNT loaded, VALID stays 1, LOST=0.
5. hit_evt coincident with a GATE edge after 9 hits → COUNT=10 and the new interval starts at 0. ENABLE=0 for a full interval with 50 hits → COUNT=0.
6. RST pulse mid-interval after 12 hits → outputs clear immediately. The next GATE edge produces no snapshot. The following interval reports only hits counted after that edge.

Source files
------------

// File: rtl/hit_rate_counter.sv
// Per-channel MPPC hit counter. It counts synchronised discriminator hits between
// GATE toggles and hands each completed interval to readout over a valid/ack snapshot.
module hit_rate_counter #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             HIT,
    input  logic             GATE,
    input  logic             ENABLE,
    output logic [CNT_W-1:0] COUNT,
    output logic             VALID,
    input  logic             ACK,
    output logic             OVF,
    output logic             LOST
);

    localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ACC_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ACC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        WAIT_EDGE = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hit_prev_r;
    logic                   hit_evt_r;
    logic                   gate_q_r;
    logic                   primed_r;
    logic [CNT_W-1:0]       acc_r;
    logic [CNT_W-1:0]       acc_s;
    logic                   ovf_acc_r;
    logic                   ovf_acc_s;
    logic [CNT_W-1:0]       snap_s;
    logic                   snap_ovf_s;
    logic                   gate_evt_s;
    logic                   counted_s;
    logic                   load_s;
    logic                   ack_ok_s;

    // HIT synchroniser chain followed by a registered rising-edge detector
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_r     <= {SYNC_STAGES{1'b0}};
            hit_prev_r <= 1'b0;
            hit_evt_r  <= 1'b0;
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], HIT};
            hit_prev_r <= sync_r[SYNC_STAGES-1];
            hit_evt_r  <= sync_r[SYNC_STAGES-1] & ~hit_prev_r;
        end
    end

    // GATE history; primed masks the first cycle so a high GATE at release is not a boundary
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gate_q_r <= 1'b0;
            primed_r <= 1'b0;
        end else begin
            gate_q_r <= GATE;
            primed_r <= 1'b1;
        end
    end

    assign gate_evt_s = (GATE ^ gate_q_r) & primed_r;
    assign counted_s  = hit_evt_r & ENABLE & (state_r == RUN);
    assign ack_ok_s   = ACK & VALID;

    // Next-state, saturating accumulator and the snapshot value including a coincident hit
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        ovf_acc_s  = ovf_acc_r;
        load_s     = 1'b0;
        if (counted_s && (acc_r != ACC_MAX)) begin
            snap_s = acc_r + ACC_ONE;
        end else begin
            snap_s = acc_r;
        end
        snap_ovf_s = ovf_acc_r | (snap_s == ACC_MAX);
        case (state_r)
            WAIT_EDGE: begin
                acc_s     = ACC_ZERO;
                ovf_acc_s = 1'b0;
                if (gate_evt_s) begin
                    state_s = RUN;
                end else begin
                    state_s = WAIT_EDGE;
                end
            end
            RUN: begin
                if (gate_evt_s) begin
                    load_s    = 1'b1;
                    acc_s     = ACC_ZERO;
                    ovf_acc_s = 1'b0;
                end else begin
                    acc_s     = snap_s;
                    ovf_acc_s = snap_ovf_s;
                end
            end
            default: begin
                state_s   = WAIT_EDGE;
                acc_s     = ACC_ZERO;
                ovf_acc_s = 1'b0;
            end
        endcase
    end

    // FSM state and interval accumulator
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= WAIT_EDGE;
            acc_r     <= ACC_ZERO;
            ovf_acc_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            ovf_acc_r <= ovf_acc_s;
        end
    end

    // Snapshot registers; an ACK in the boundary cycle consumes the old snapshot, so no loss
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            COUNT <= ACC_ZERO;
            VALID <= 1'b0;
            OVF   <= 1'b0;
            LOST  <= 1'b0;
        end else if (load_s) begin
            COUNT <= snap_s;
            OVF   <= snap_ovf_s;
            VALID <= 1'b1;
            LOST  <= LOST | (VALID & ~ACK);
        end else if (ack_ok_s) begin
            VALID <= 1'b0;
            LOST  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hit_rate_counter.sv
// Randomised and directed bench for hit_rate_counter: an interval-level hit model
// feeds a per-cycle expectation queue that a negedge monitor drains and compares.
module tb_hit_rate_counter;

    localparam int CW   = 6;
    localparam int SS   = 3;
    localparam int MAXV = (1 << CW) - 1;

    typedef struct packed {
        logic [CW-1:0] count;
        logic          valid;
        logic          ovf;
        logic          lost;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST, HIT, GATE, ENABLE, ACK;
    logic [CW-1:0] COUNT;
    logic          VALID, OVF, LOST;

    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    exp_t sb[$];
    int   pend[$];

    bit   m_run, m_primed, m_hprev, m_gprev, m_valid, m_ovf, m_lost;
    int   m_n, m_count;

    hit_rate_counter #(.CNT_W(CW), .SYNC_STAGES(SS)) dut (
        .CLK(CLK), .RST(RST), .HIT(HIT), .GATE(GATE), .ENABLE(ENABLE),
        .COUNT(COUNT), .VALID(VALID), .ACK(ACK), .OVF(OVF), .LOST(LOST)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc_n, act, exp);
        end
    endtask

    // One clock: apply the spec rules to the inputs sampled at this edge
    task automatic step();
        exp_t e;
        int   c, tot;
        bit   gevt, ackok;
        @(posedge CLK);
        cyc_n++;
        if (RST) begin
            m_run = 0; m_primed = 0; m_n = 0; m_count = 0;
            m_valid = 0; m_ovf = 0; m_lost = 0;
            pend.delete();
        end else begin
            c = 0;
            if (pend.size() > 0 && pend[0] == cyc_n) begin
                void'(pend.pop_front());
                if (ENABLE && m_run) c = 1;
            end
            if (HIT && !m_hprev) pend.push_back(cyc_n + SS + 1);
            gevt  = m_primed && (GATE != m_gprev);
            ackok = ACK && m_valid;
            if (gevt && m_run) begin
                tot     = m_n + c;
                m_count = (tot > MAXV) ? MAXV : tot;
                m_ovf   = (tot >= MAXV);
                if (m_valid && !ACK) m_lost = 1;
                m_valid = 1;
                m_n     = 0;
            end else begin
                if (m_run) m_n += c;
                if (ackok) begin
                    m_valid = 0;
                    m_lost  = 0;
                end
            end
            if (gevt && !m_run) begin
                m_run = 1;
                m_n   = 0;
            end
            m_primed = 1;
        end
        m_hprev = HIT;
        m_gprev = GATE;
        e.count = m_count[CW-1:0];
        e.valid = m_valid;
        e.ovf   = m_ovf;
        e.lost  = m_lost;
        sb.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        HIT = 1'b0;
        repeat (n) step();
    endtask

    task automatic hits(input int n);
        repeat (n) begin
            HIT = 1'b1; step(); step();
            HIT = 1'b0; step(); step();
        end
    endtask

    task automatic toggle();
        GATE = ~GATE;
        step();
    endtask

    task automatic ack1();
        ACK = 1'b1; step();
        ACK = 1'b0;
    endtask

    // Monitor: compares every DUT output against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("count", COUNT, e.count);
                cmp("valid", VALID, e.valid);
                cmp("ovf",   OVF,   e.ovf);
                cmp("lost",  LOST,  e.lost);
            end
        end
    end

    initial begin
        int hl;
        RST = 1'b1; GATE = 1'b1; HIT = 1'b0; ENABLE = 1'b1; ACK = 1'b0;
        repeat (3) step();
        RST = 1'b0;

        // Reset release with GATE high; first toggle only arms counting
        while ($time < 100) step();
        toggle();
        idle(2);
        cmp("t1_no_snap", VALID, 0);
        hits(37); idle(SS + 2); toggle();
        cmp("t1_count", COUNT, 37);
        cmp("t1_valid", VALID, 1);
        cmp("t1_ovf", OVF, 0);
        ack1();
        cmp("t1_ack", VALID, 0);

        // Saturation, then a clean interval
        hits(MAXV + 7); idle(SS + 2); toggle();
        cmp("t2_sat", COUNT, MAXV);
        cmp("t2_ovf", OVF, 1);
        ack1();
        hits(3); idle(SS + 2); toggle();
        cmp("t2_next", COUNT, 3);
        cmp("t2_ovf_clr", OVF, 0);
        ack1();

        // Overwrite without ACK sets LOST; an accepted ACK clears it
        hits(5); idle(SS + 2); toggle();
        hits(8); idle(SS + 2); toggle();
        cmp("t3_count", COUNT, 8);
        cmp("t3_valid", VALID, 1);
        cmp("t3_lost", LOST, 1);
        ack1();
        cmp("t3_valid_clr", VALID, 0);
        cmp("t3_lost_clr", LOST, 0);

        // ACK coincident with a boundary
        hits(4); idle(SS + 2); toggle();
        hits(2); idle(SS + 2);
        ACK = 1'b1; toggle(); ACK = 1'b0;
        cmp("t4_count", COUNT, 2);
        cmp("t4_valid", VALID, 1);
        cmp("t4_lost", LOST, 0);
        ack1();

        // Hit event lands in the boundary cycle
        hits(9); idle(SS + 2);
        HIT = 1'b1; step(); step();
        HIT = 1'b0; repeat (SS - 1) step();
        toggle();
        cmp("t5_coinc", COUNT, 10);
        ack1();
        idle(6); toggle();
        cmp("t5_fresh", COUNT, 0);
        ack1();
        ENABLE = 1'b0; hits(50); idle(SS + 2); toggle(); ENABLE = 1'b1;
        cmp("t5_disabled", COUNT, 0);
        hits(2); idle(SS + 2);
        toggle(); toggle(); toggle();
        cmp("t5_b2b_lost", LOST, 1);
        ack1();

        // Reset mid-interval
        hits(12); idle(SS + 2); toggle();
        hits(12); idle(SS + 2);
        @(negedge CLK); #1;
        RST = 1'b1; #1;
        cmp("t6_rst_count", COUNT, 0);
        cmp("t6_rst_valid", VALID, 0);
        cmp("t6_rst_ovf", OVF, 0);
        cmp("t6_rst_lost", LOST, 0);
        step(); step();
        RST = 1'b0;
        idle(3); hits(4); idle(SS + 2); toggle();
        idle(2);
        cmp("t6_no_snap", VALID, 0);
        hits(6); idle(SS + 2); toggle();
        cmp("t6_count", COUNT, 6);

        // Randomised traffic
        hl = 0;
        for (int i = 0; i < 2500; i++) begin
            if (hl == 0) begin
                HIT = ~HIT;
                hl  = $urandom_range(2, 4);
            end
            hl--;
            ENABLE = ($urandom_range(0, 9) != 0);
            ACK    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) GATE = ~GATE;
            if ($urandom_range(0, 299) == 0) begin
                GATE = ~GATE; step();
                GATE = ~GATE; step();
                hl = (hl > 1) ? hl - 2 : 0;
                GATE = ~GATE;
            end
            step();
        end
        ACK = 1'b0; ENABLE = 1'b1;
        idle(8);

        @(negedge CLK); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
